// File: rtl/w5300_socket_tx.sv
// Transmit-path engine for one W5300 socket: checks free TX memory, streams a buffered frame
// into Sn_TX_FIFOR, commits the length through Sn_TX_WRSR and issues SEND.
module w5300_socket_tx #(
   parameter int unsigned SOCKET     = 0,
   parameter int unsigned BUF_AW     = 16,
   parameter int unsigned POLL_LIMIT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic              tx_req_i,
   input  logic [15:0]       tx_len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [BUF_AW-1:0] buf_addr_o,
   input  logic [15:0]       buf_data_i,
   output logic [10:0]       addr_o,
   output logic [15:0]       wr_data_o,
   input  logic [15:0]       rd_data_i,
   input  logic              op_state_i
);

   localparam logic OpRd = 1'b0;
   localparam logic OpWr = 1'b1;

   localparam logic [9:0] Base      = 10'(32'h200 + 32'h40 * SOCKET);
   localparam logic [9:0] RegCr     = Base + 10'h02;
   localparam logic [9:0] RegWrsrH  = Base + 10'h20;
   localparam logic [9:0] RegWrsrL  = Base + 10'h22;
   localparam logic [9:0] RegFsrH   = Base + 10'h24;
   localparam logic [9:0] RegFsrL   = Base + 10'h26;
   localparam logic [9:0] RegFifo   = Base + 10'h2E;
   localparam logic [15:0] CmdSend  = 16'h0020;

   localparam int unsigned PollW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
   localparam logic [PollW-1:0] PollLast = PollW'(POLL_LIMIT - 1);

   typedef enum logic [3:0] {
      StIdle,
      StRdFsrH,
      StRdFsrL,
      StFetch,
      StFetchWait,
      StWrFifo,
      StWrWrsrH,
      StWrWrsrL,
      StWrCr,
      StPollCr,
      StDone,
      StErr
   } state_e;

   state_e           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [15:0]      words_q, words_d;
   logic [15:0]      idx_q, idx_d;
   logic [PollW-1:0] poll_q, poll_d;
   logic             fsr_hi_q, fsr_hi_d;
   logic [15:0]      word_q, word_d;

   logic             ack;
   logic [16:0]      free;
   logic [15:0]      idx_inc;
   logic [15:0]      req_words;

   // op_state only counts while this block owns the bus
   assign ack       = enable_i & op_state_i;
   assign free      = {fsr_hi_q, rd_data_i};
   assign idx_inc   = idx_q + 16'd1;
   assign req_words = {1'b0, tx_len_i[15:1]} + {15'd0, tx_len_i[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         len_q    <= '0;
         words_q  <= '0;
         idx_q    <= '0;
         poll_q   <= '0;
         fsr_hi_q <= 1'b0;
         word_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         words_q  <= words_d;
         idx_q    <= idx_d;
         poll_q   <= poll_d;
         fsr_hi_q <= fsr_hi_d;
         word_q   <= word_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      words_d  = words_q;
      idx_d    = idx_q;
      poll_d   = poll_q;
      fsr_hi_d = fsr_hi_q;
      word_d   = word_q;
      unique case (state_q)
         StIdle: begin
            if (enable_i && tx_req_i) begin
               if (tx_len_i == 16'd0) begin
                  state_d = StErr;
               end else begin
                  len_d   = tx_len_i;
                  words_d = req_words;
                  idx_d   = '0;
                  poll_d  = '0;
                  state_d = StRdFsrH;
               end
            end
         end
         StRdFsrH: begin
            if (ack) begin
               fsr_hi_d = rd_data_i[0];
               state_d  = StRdFsrL;
            end
         end
         StRdFsrL: begin
            if (ack) begin
               if (free >= {1'b0, len_q}) begin
                  poll_d  = '0;
                  state_d = StFetch;
               end else if (poll_q == PollLast) begin
                  state_d = StErr;
               end else begin
                  poll_d  = poll_q + 1'b1;
                  state_d = StRdFsrH;
               end
            end
         end
         // buf_addr follows idx_q, so the word is valid one cycle after entering StFetch
         StFetch: begin
            if (enable_i) state_d = StFetchWait;
         end
         StFetchWait: begin
            if (enable_i) begin
               word_d  = buf_data_i;
               state_d = StWrFifo;
            end
         end
         StWrFifo: begin
            if (ack) begin
               idx_d   = idx_inc;
               state_d = (idx_inc == words_q) ? StWrWrsrH : StFetch;
            end
         end
         StWrWrsrH: begin
            if (ack) state_d = StWrWrsrL;
         end
         StWrWrsrL: begin
            if (ack) state_d = StWrCr;
         end
         StWrCr: begin
            if (ack) begin
               poll_d  = '0;
               state_d = StPollCr;
            end
         end
         StPollCr: begin
            if (ack) begin
               if (rd_data_i[7:0] == 8'h00) begin
                  state_d = StDone;
               end else if (poll_q == PollLast) begin
                  state_d = StErr;
               end else begin
                  poll_d = poll_q + 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o     = 1'b1;
      done_o     = 1'b0;
      error_o    = 1'b0;
      buf_addr_o = idx_q[BUF_AW-1:0];
      addr_o     = {OpRd, 10'h000};
      wr_data_o  = 16'h0000;
      unique case (state_q)
         StIdle:    busy_o = 1'b0;
         StRdFsrH:  addr_o = {OpRd, RegFsrH};
         StRdFsrL:  addr_o = {OpRd, RegFsrL};
         StWrFifo: begin
            addr_o    = {OpWr, RegFifo};
            wr_data_o = word_q;
         end
         StWrWrsrH: addr_o = {OpWr, RegWrsrH};
         StWrWrsrL: begin
            addr_o    = {OpWr, RegWrsrL};
            wr_data_o = len_q;
         end
         StWrCr: begin
            addr_o    = {OpWr, RegCr};
            wr_data_o = CmdSend;
         end
         StPollCr:  addr_o = {OpRd, RegCr};
         StDone: begin
            busy_o = 1'b0;
            done_o = 1'b1;
         end
         StErr: begin
            busy_o  = 1'b0;
            error_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_w5300_socket_tx.sv
// Directed bench for w5300_socket_tx: a register-level chip model answers FSR/CR reads and logs
// every access, which is compared against the expected transaction list for each frame.
module tb_w5300_socket_tx;

   localparam logic [10:0] A_FSRH  = 11'h264;
   localparam logic [10:0] A_FSRL  = 11'h266;
   localparam logic [10:0] A_FIFO  = 11'h66E;
   localparam logic [10:0] A_WRSRH = 11'h660;
   localparam logic [10:0] A_WRSRL = 11'h662;
   localparam logic [10:0] A_CRW   = 11'h642;
   localparam logic [10:0] A_CRR   = 11'h242;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        tx_req;
   logic [15:0] tx_len;
   logic        busy, done, error;
   logic [15:0] buf_addr;
   logic [15:0] buf_data = 16'h0000;
   logic [10:0] addr;
   logic [15:0] wr_data;
   logic [15:0] rd_data = 16'h0000;
   logic        op_state = 1'b0;

   logic [15:0] buf_mem [0:63];
   logic [26:0] log_q [$];
   logic [26:0] exp_q [$];

   int          n_assert = 0;
   int          n_fail = 0;
   int          lat_cnt = 0;
   int          fsr_pairs = 0;
   int          fsr_low_cnt = 0;
   logic [31:0] fsr_low_val = 32'h0;
   logic [31:0] fsr_val = 32'h0;
   logic [31:0] fv;
   int          cr_reads = 0;
   int          cr_busy = 0;
   int          fifo_wr_cnt = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          d0, e0, nlog;

   w5300_socket_tx #(
      .SOCKET     (1),
      .BUF_AW     (16),
      .POLL_LIMIT (12)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable),
      .tx_req_i   (tx_req),
      .tx_len_i   (tx_len),
      .busy_o     (busy),
      .done_o     (done),
      .error_o    (error),
      .buf_addr_o (buf_addr),
      .buf_data_i (buf_data),
      .addr_o     (addr),
      .wr_data_o  (wr_data),
      .rd_data_i  (rd_data),
      .op_state_i (op_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) buf_data <= buf_mem[buf_addr[5:0]];

   // Chip model: an access completes after its address has been stable for three cycles
   always @(posedge clk) begin
      op_state <= 1'b0;
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (!enable || addr == 11'h000 || op_state) begin
         lat_cnt = 0;
      end else if (lat_cnt == 2) begin
         lat_cnt = 0;
         op_state <= 1'b1;
         log_q.push_back({addr, addr[10] ? wr_data : 16'h0000});
         fv = (fsr_pairs < fsr_low_cnt) ? fsr_low_val : fsr_val;
         case (addr)
            A_FSRH: rd_data <= fv[31:16];
            A_FSRL: begin
               rd_data <= fv[15:0];
               fsr_pairs++;
            end
            A_CRR: begin
               rd_data <= (cr_reads < cr_busy) ? 16'h0020 : 16'h0000;
               cr_reads++;
            end
            A_FIFO: begin
               rd_data <= 16'hDEAD;
               fifo_wr_cnt++;
            end
            default: rd_data <= 16'hDEAD;
         endcase
      end else begin
         lat_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [10:0] a, input logic [15:0] d);
      exp_q.push_back({a, a[10] ? d : 16'h0000});
   endtask

   task automatic exp_frame(input logic [15:0] len, input int pairs, input int cr_polls);
      exp_q.delete();
      for (int i = 0; i < pairs; i++) begin
         push_exp(A_FSRH, 16'h0);
         push_exp(A_FSRL, 16'h0);
      end
      for (int i = 0; i < (int'(len) + 1) / 2; i++) push_exp(A_FIFO, buf_mem[6'(i)]);
      push_exp(A_WRSRH, 16'h0000);
      push_exp(A_WRSRL, len);
      push_exp(A_CRW, 16'h0020);
      for (int i = 0; i <= cr_polls; i++) push_exp(A_CRR, 16'h0);
   endtask

   task automatic check_log(input string tag);
      chk($sformatf("%s:count", tag), 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s:acc%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
   endtask

   task automatic clear_model();
      log_q.delete();
      exp_q.delete();
      fsr_pairs   = 0;
      cr_reads    = 0;
      fifo_wr_cnt = 0;
   endtask

   task automatic start_frame(input logic [15:0] len);
      @(negedge clk);
      tx_len = len;
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int s0;
      s0 = done_cnt + err_cnt;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt + err_cnt != s0) break;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      tx_req = 1'b0;
      tx_len = 16'h0;
      for (int i = 0; i < 64; i++) buf_mem[i] = 16'(16'h5A00 ^ (i * 257));
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      chk("rst_buf_addr", 32'(buf_addr), 32'h0);
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_wr_data", 32'(wr_data), 32'h0);

      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_addr", 32'(addr), 32'h0);
      chk("idle_no_access", 32'(log_q.size()), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);

      // 4-byte frame, plenty of free space
      buf_mem[0] = 16'hA1B2;
      buf_mem[1] = 16'hC3D4;
      fsr_low_cnt = 0;
      fsr_val = 32'h0000_2000;
      cr_busy = 0;
      clear_model();
      d0 = done_cnt; e0 = err_cnt;
      start_frame(16'd4);
      chk("len4_busy", 32'(busy), 32'h1);
      wait_end(500);
      exp_frame(16'd4, 1, 0);
      check_log("len4");
      chk("len4_done", 32'(done_cnt - d0), 32'd1);
      chk("len4_err", 32'(err_cnt - e0), 32'd0);
      chk("len4_busy_end", 32'(busy), 32'h0);

      // odd length, CR busy for two polls
      buf_mem[0] = 16'h1111;
      buf_mem[1] = 16'h2222;
      buf_mem[2] = 16'h3344;
      cr_busy = 2;
      clear_model();
      d0 = done_cnt; e0 = err_cnt;
      start_frame(16'd5);
      wait_end(500);
      exp_frame(16'd5, 1, 2);
      check_log("len5");
      chk("len5_done", 32'(done_cnt - d0), 32'd1);
      chk("len5_err", 32'(err_cnt - e0), 32'd0);

      // FSR too small twice, then enough
      for (int i = 0; i < 64; i++) buf_mem[i] = 16'(16'h5A00 ^ (i * 257));
      fsr_low_cnt = 2;
      fsr_low_val = 32'h0000_0002;
      fsr_val = 32'h0000_0100;
      cr_busy = 0;
      clear_model();
      d0 = done_cnt; e0 = err_cnt;
      start_frame(16'd64);
      wait_end(2000);
      exp_frame(16'd64, 3, 0);
      check_log("len64");
      chk("len64_done", 32'(done_cnt - d0), 32'd1);
      chk("len64_err", 32'(err_cnt - e0), 32'd0);

      // FSR stuck at zero: twelve read pairs, then error
      fsr_low_cnt = 1000000;
      fsr_low_val = 32'h0;
      clear_model();
      d0 = done_cnt; e0 = err_cnt;
      start_frame(16'd8);
      wait_end(2000);
      exp_q.delete();
      for (int i = 0; i < 12; i++) begin
         push_exp(A_FSRH, 16'h0);
         push_exp(A_FSRL, 16'h0);
      end
      check_log("fsr_stuck");
      chk("fsr_stuck_fifo", 32'(fifo_wr_cnt), 32'd0);
      chk("fsr_stuck_err", 32'(err_cnt - e0), 32'd1);
      chk("fsr_stuck_done", 32'(done_cnt - d0), 32'd0);

      // zero length: error on the next cycle, no access
      clear_model();
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk);
      tx_len = 16'd0;
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      chk("len0_error", 32'(error), 32'h1);
      chk("len0_busy", 32'(busy), 32'h0);
      repeat (4) @(negedge clk);
      chk("len0_no_access", 32'(log_q.size()), 32'd0);
      chk("len0_err_cnt", 32'(err_cnt - e0), 32'd1);
      chk("len0_done_cnt", 32'(done_cnt - d0), 32'd0);

      // enable dropped while the first FIFOR write is presented
      buf_mem[0] = 16'hA1B2;
      buf_mem[1] = 16'hC3D4;
      fsr_low_cnt = 0;
      fsr_val = 32'h0000_2000;
      clear_model();
      d0 = done_cnt;
      start_frame(16'd4);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (addr === A_FIFO) break;
      end
      enable = 1'b0;
      nlog = log_q.size();
      repeat (8) @(negedge clk);
      chk("frz_addr", 32'(addr), 32'(A_FIFO));
      chk("frz_wr_data", 32'(wr_data), 32'hA1B2);
      chk("frz_busy", 32'(busy), 32'h1);
      chk("frz_no_access", 32'(log_q.size()), 32'(nlog));
      enable = 1'b1;
      wait_end(500);
      exp_frame(16'd4, 1, 0);
      check_log("frz");
      chk("frz_done", 32'(done_cnt - d0), 32'd1);

      // reset during the 10th FIFOR write of a 40-byte frame
      for (int i = 0; i < 64; i++) buf_mem[i] = 16'(16'h5A00 ^ (i * 257));
      clear_model();
      start_frame(16'd40);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (fifo_wr_cnt == 9 && addr === A_FIFO && op_state === 1'b0) break;
      end
      chk("mid_reached", 32'(fifo_wr_cnt), 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_addr", 32'(addr), 32'h0);
      chk("mid_wr_data", 32'(wr_data), 32'h0);
      chk("mid_buf_addr", 32'(buf_addr), 32'h0);
      nlog = log_q.size();
      repeat (5) @(negedge clk);
      chk("mid_no_access", 32'(log_q.size()), 32'(nlog));
      rst_n = 1'b1;

      buf_mem[0] = 16'hA1B2;
      buf_mem[1] = 16'hC3D4;
      clear_model();
      d0 = done_cnt; e0 = err_cnt;
      start_frame(16'd4);
      wait_end(500);
      exp_frame(16'd4, 1, 0);
      check_log("post_rst");
      chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
      chk("post_rst_err", 32'(err_cnt - e0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
